serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the combinational bit slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one operand bit pair per clock through a single full adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is sampled only in IDLE; busy is high from the accepting edge until
  // DONE is left; done pulses for one cycle when sum/cout are final and they hold until
  // the next accepted start.

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (count == CW'(WIDTH - 1));
  assign sum      = sum_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cout   <= 1'b0;
      carry  <= 1'b0;
      count  <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            count  <= '0;
            sum_sr <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_co;
          count  <= count + 1'b1;
          if (last_bit) begin
            cout  <= fa_co;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB slice here.
            ovf   <= carry ^ fa_co;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
